// File: rtl/spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// spike_rate_decoder
//
// Purpose:
//   Receive-side decoder for a 1-bit neuron spike line. Counts rising-edge
//   spike events over back-to-back windows of WINDOW_LEN cycles (rate code)
//   and measures the interval between the two most recent events (ISI).
//   The rate result is offered over a valid/ready handshake; windows keep
//   running while a result waits, so no spike is ever dropped.
//
// Parameters:
//   WINDOW_LEN  window length in clk cycles (>= 2)
//   CNT_W       width of the saturating spike-count result
//   ISI_W       width of the saturating ISI result
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   enable        in   1 = decode, 0 = idle (partial window discarded)
//   spike_in      in   spike line from the neuron
//   rate_count    out  spike count of the last completed window
//   rate_sat      out  last window's count saturated
//   rate_overrun  out  sticky: a result was overwritten before acceptance
//   rate_valid    out  rate result available
//   rate_ready    in   consumer accepts the rate result
//   isi           out  cycles between the two most recent events (saturating)
//   isi_valid     out  two events seen since leaving IDLE
//   o_dbg_state   out  FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: a rate result transfers on any cycle where rate_valid and
//   rate_ready are both high; rate_valid falls on the following cycle unless
//   a new window closes on that same cycle. While rate_valid is high and no
//   transfer occurs, rate_count/rate_sat stay stable until the next window
//   close, which overwrites them and sets rate_overrun.
//
// Build option:
//   SPIKE_SYNC_EN  when defined, spike_in passes through a 2-flop
//                  synchronizer before edge detection (2 cycles of latency).
// ---------------------------------------------------------------------------
module spike_rate_decoder #(
  parameter int WINDOW_LEN = 16,
  parameter int CNT_W      = 8,
  parameter int ISI_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             spike_in,
  output logic [CNT_W-1:0] rate_count,
  output logic             rate_sat,
  output logic             rate_overrun,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid,
  output logic             o_dbg_state
);

  localparam int WIN_W = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ISI_W-1:0] ISI_MAX  = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // -------------------------------------------------------------------------
  // Spike source: optionally synchronized, then rising-edge detected.
  // -------------------------------------------------------------------------
  logic w_spike_src;
  logic r_spike_prev;
  logic w_event;

`ifdef SPIKE_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= spike_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_spike_src = r_sync2;
`else
  assign w_spike_src = spike_in;
`endif

  // Edge history runs in every state so a line already high when RUN starts
  // is not mistaken for a fresh event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_spike_prev <= 1'b0;
    end else begin
      r_spike_prev <= w_spike_src;
    end
  end

  assign w_event = w_spike_src & ~r_spike_prev;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (enable)  w_state_next = S_RUN;
      S_RUN:  if (!enable) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_dbg_state = r_state;

  // A RUN cycle only does work while enable is still high; the cycle that
  // sees enable low is the exit cycle and its partial window is thrown away.
  logic w_run_active;
  logic w_enter_run;
  logic w_close;

  assign w_run_active = (r_state == S_RUN) && enable;
  assign w_enter_run  = (r_state == S_IDLE) && enable;

  // -------------------------------------------------------------------------
  // Window / spike counters
  // -------------------------------------------------------------------------
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_spike_cnt;
  logic             r_cnt_sat;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_sat_inc;

  assign w_close = w_run_active && (r_win_cnt == WIN_LAST);

  // Count including this cycle's event; also used as the result at close so
  // an event on the last window cycle is not lost.
  assign w_cnt_inc = (w_event && (r_spike_cnt != CNT_MAX)) ? r_spike_cnt + 1'b1
                                                           : r_spike_cnt;
  assign w_sat_inc = r_cnt_sat | (w_event && (r_spike_cnt == CNT_MAX));

  always_ff @(posedge clk) begin
    if (rst || !w_run_active) begin
      r_win_cnt   <= '0;
      r_spike_cnt <= '0;
      r_cnt_sat   <= 1'b0;
    end else if (w_close) begin
      // Next window starts immediately on the following cycle.
      r_win_cnt   <= '0;
      r_spike_cnt <= '0;
      r_cnt_sat   <= 1'b0;
    end else begin
      r_win_cnt   <= r_win_cnt + 1'b1;
      r_spike_cnt <= w_cnt_inc;
      r_cnt_sat   <= w_sat_inc;
    end
  end

  // -------------------------------------------------------------------------
  // Rate result register and handshake
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] r_rate_count;
  logic             r_rate_sat;
  logic             r_rate_valid;
  logic             r_rate_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rate_count   <= '0;
      r_rate_sat     <= 1'b0;
      r_rate_valid   <= 1'b0;
      r_rate_overrun <= 1'b0;
    end else if (w_close) begin
      r_rate_count <= w_cnt_inc;
      r_rate_sat   <= w_sat_inc;
      r_rate_valid <= 1'b1;
      // Overwriting an unaccepted result is an overrun; a transfer on the
      // close cycle means the old result was consumed in time.
      if (r_rate_valid && !rate_ready) begin
        r_rate_overrun <= 1'b1;
      end
    end else if (r_rate_valid && rate_ready) begin
      r_rate_valid <= 1'b0;
    end
  end

  assign rate_count   = r_rate_count;
  assign rate_sat     = r_rate_sat;
  assign rate_valid   = r_rate_valid;
  assign rate_overrun = r_rate_overrun;

  // -------------------------------------------------------------------------
  // Inter-spike interval
  // -------------------------------------------------------------------------
  logic [ISI_W-1:0] r_isi_cnt;
  logic             r_isi_armed;
  logic [ISI_W-1:0] r_isi;
  logic             r_isi_valid;
  logic [ISI_W-1:0] w_isi_inc;

  // isi_cnt counts cycles since the last event; the interval includes the
  // event cycle itself, hence the +1 when it is captured.
  assign w_isi_inc = (r_isi_cnt == ISI_MAX) ? ISI_MAX : r_isi_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_isi_cnt   <= '0;
      r_isi_armed <= 1'b0;
      r_isi       <= '0;
      r_isi_valid <= 1'b0;
    end else if (w_enter_run) begin
      // Fresh history on every RUN entry; the last isi value is kept but no
      // longer flagged valid until two new events arrive.
      r_isi_cnt   <= '0;
      r_isi_armed <= 1'b0;
      r_isi_valid <= 1'b0;
    end else if (w_run_active) begin
      if (w_event) begin
        r_isi_cnt   <= '0;
        r_isi_armed <= 1'b1;
        if (r_isi_armed) begin
          r_isi       <= w_isi_inc;
          r_isi_valid <= 1'b1;
        end
      end else begin
        r_isi_cnt <= w_isi_inc;
      end
    end else begin
      // IDLE or the exit cycle: isi/isi_valid hold, counters park at zero.
      r_isi_cnt   <= '0;
      r_isi_armed <= 1'b0;
    end
  end

  assign isi       = r_isi;
  assign isi_valid = r_isi_valid;

endmodule
